// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub_pkg;

    // FSM encoding: idle, shifting bits, one-cycle completion
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Bit-counter width for a given operand width; at least one bit
    function automatic int cnt_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done request-result bundle of the serial subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    // requester side
    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    // subtractor side
    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
endinterface

// File: rtl/full_subtractor.sv
// Combinational 1-bit subtractor cell: diff = a - b - bin.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);
    // Borrow when b exceeds a, or when a==b and a borrow comes in
    always_comb begin
        diff = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial ripple subtractor: one full_subtractor cell, registered borrow,
// operands consumed LSB first, result shifted in from the top.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_subtractor_if.slave bus
);
    localparam int CNT_W = cnt_w(WIDTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh, b_sh, diff_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               brw_q, bout_q;
    logic               load, shift, last;
    logic               cell_d, cell_bo;

    full_subtractor u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (brw_q),
        .diff (cell_d),
        .bout (cell_bo)
    );

    assign last = (cnt_q == CNT_W'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state plus load/shift strobes; start in RUN is deliberately ignored
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                shift = 1'b1;
                if (last) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: capture operands on accept, then one bit per clock.
    // bout only moves on the last bit so it is stable while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            diff_q <= '0;
            cnt_q  <= '0;
            brw_q  <= 1'b0;
            bout_q <= 1'b0;
        end else if (load) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            brw_q <= bus.bin;
            cnt_q <= '0;
        end else if (shift) begin
            diff_q <= {cell_d, diff_q[WIDTH-1:1]};
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            brw_q  <= cell_bo;
            cnt_q  <= cnt_q + CNT_W'(1);
            if (last) bout_q <= cell_bo;
        end
    end

    assign bus.busy = (state_q == ST_RUN);
    assign bus.done = (state_q == ST_DONE);
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed checks of serial_subtractor against an
// arithmetic reference, plus an exhaustive check of the 1-bit cell.
module tb_serial_subtractor;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic last_bout;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic fs_a, fs_b, fs_bin, fs_diff, fs_bout;
    full_subtractor u_fs (
        .a    (fs_a),
        .b    (fs_b),
        .bin  (fs_bin),
        .diff (fs_diff),
        .bout (fs_bout)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer subtraction
    task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                         output logic [W-1:0] d, output logic bo);
        longint r;
        r  = longint'(av) - longint'(bv) - longint'(bi);
        d  = W'(r);
        bo = (longint'(av) < longint'(bv) + longint'(bi));
    endtask

    // One operation; pulse_at>0 injects a stray start with junk operands mid-run
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                          input int pulse_at, input string tag);
        logic [W-1:0] ed;
        logic         eb;
        int           cyc, bcnt, bchg;
        bit           seen;
        model(av, bv, bi, ed, eb);
        @(negedge clk);
        bus.start = 1'b1; bus.a = av; bus.b = bv; bus.bin = bi;
        @(posedge clk);
        cyc = 0; bcnt = 0; bchg = 0; seen = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                bus.start = 1'b0;
                bus.a = W'($urandom); bus.b = W'($urandom); bus.bin = 1'($urandom);
            end
            if (pulse_at != 0 && cyc == pulse_at) begin
                bus.start = 1'b1;
                bus.a = W'($urandom); bus.b = W'($urandom);
            end
            if (pulse_at != 0 && cyc == pulse_at + 1) bus.start = 1'b0;
            if (bus.busy) begin
                bcnt++;
                if (bus.bout !== last_bout) bchg++;
            end
            if (bus.done) seen = 1;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'(W + 1));
        chk({tag, "_busy_cycles"}, 64'(bcnt), 64'(W));
        chk({tag, "_bout_stable"}, 64'(bchg), 64'd0);
        chk({tag, "_diff"}, 64'(bus.diff), 64'(ed));
        chk({tag, "_bout"}, 64'(bus.bout), 64'(eb));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
        chk({tag, "_diff_hold"}, 64'(bus.diff), 64'(ed));
        last_bout = eb;
    endtask

    initial begin
        int           cyc, dcnt;
        bit           seen;
        logic [W-1:0] ed;
        logic         eb;

        rst_n = 1'b0;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
        last_bout = 1'b0;

        // 1-bit cell, all rows
        for (int i = 0; i < 8; i++) begin
            int r;
            {fs_a, fs_b, fs_bin} = 3'(i);
            #1;
            r = int'(fs_a) - int'(fs_b) - int'(fs_bin);
            chk($sformatf("fs_diff_%0d", i), 64'(fs_diff), 64'(r & 1));
            chk($sformatf("fs_bout_%0d", i), 64'(fs_bout), 64'(r < 0));
        end

        #20;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_diff", 64'(bus.diff), 64'd0);
        chk("rst_bout", 64'(bus.bout), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // directed
        run_op(8'h2A, 8'h15, 1'b0, 0, "basic");
        run_op(8'h00, 8'h01, 1'b0, 0, "under");
        run_op(8'h80, 8'h80, 1'b1, 0, "eq_bin");
        run_op(8'hFF, 8'h00, 1'b0, 0, "ff_0");
        run_op(8'h33, 8'h33, 1'b0, 0, "eq_zero");

        // back-to-back: start held through DONE
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h01; bus.bin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.a = 8'h05; bus.b = 8'h07;
        cyc = 1; seen = bus.done;
        while (!seen && cyc < 40) begin
            @(negedge clk); cyc++;
            if (bus.done) seen = 1;
        end
        chk("b2b_lat1", 64'(cyc), 64'(W + 1));
        chk("b2b_diff1", 64'(bus.diff), 64'h0F);
        chk("b2b_bout1", 64'(bus.bout), 64'd0);
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b_no_idle", 64'(bus.busy), 64'd1);
        cyc = 1; seen = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk); cyc++;
            if (bus.done) seen = 1;
        end
        chk("b2b_lat2", 64'(cyc), 64'(W + 1));
        chk("b2b_diff2", 64'(bus.diff), 64'hFE);
        chk("b2b_bout2", 64'(bus.bout), 64'd1);
        last_bout = 1'b1;

        // stray start mid-run
        run_op(8'h9C, 8'h47, 1'b1, 3, "midstart");

        // reset in the middle of RUN
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'hF0; bus.b = 8'h0F; bus.bin = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        chk("abort_busy_before", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_diff", 64'(bus.diff), 64'd0);
        chk("abort_bout", 64'(bus.bout), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (bus.done) dcnt++;
        end
        chk("abort_no_done", 64'(dcnt), 64'd0);
        last_bout = 1'b0;
        run_op(8'h64, 8'h65, 1'b0, 0, "post_rst");

        // random operations
        for (int n = 0; n < 24; n++) begin
            logic [W-1:0] ra, rb;
            logic         rbin;
            ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
            model(ra, rb, rbin, ed, eb);
            run_op(ra, rb, rbin, (n % 3 == 0) ? int'($urandom_range(2, 6)) : 0,
                   $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
